// File: rtl/gravity_sensor_in_pkg.sv
// ============================================================================
// gravity_sensor_in_pkg : SPI receive state encoding and sensor register map
// Revision: 1.0
// ============================================================================
`default_nettype none

package gravity_sensor_in_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4,
      ST_SKIP = 3'd5
   } spi_state_e;

   // Register map shared with the address-driving transmitter.
   localparam logic [7:0] DEF_READ_CMD  = 8'h0B;
   localparam logic [7:0] DEF_X_LO_ADDR = 8'h0E;
   localparam logic [7:0] DEF_X_HI_ADDR = 8'h0F;
   localparam logic [7:0] DEF_Y_LO_ADDR = 8'h10;
   localparam logic [7:0] DEF_Y_HI_ADDR = 8'h11;

endpackage

`default_nettype wire

// File: rtl/gravity_sensor_in_spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : N-stage synchroniser with rise/fall strobes on the synced copy
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q, prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
      prev_d  = chain_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= {STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign q    = chain_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

`default_nettype wire

// File: rtl/gravity_sensor_in.sv
// ============================================================================
// gravity_sensor_in : SPI read-frame snooper pairing lo/hi bytes into X/Y samples
// Revision: 1.0
// ============================================================================
`default_nettype none

module gravity_sensor_in
   import gravity_sensor_in_pkg::*;
#(
   parameter logic [7:0] READ_CMD    = DEF_READ_CMD,
   parameter logic [7:0] X_LO_ADDR   = DEF_X_LO_ADDR,
   parameter logic [7:0] X_HI_ADDR   = DEF_X_HI_ADDR,
   parameter logic [7:0] Y_LO_ADDR   = DEF_Y_LO_ADDR,
   parameter logic [7:0] Y_HI_ADDR   = DEF_Y_HI_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clkcs,
   input  logic        sclk,
   input  logic        adress,
   input  logic        miso,
   output logic [15:0] x_data,
   output logic [15:0] y_data,
   output logic        x_valid,
   output logic        y_valid,
   output logic        frame_err
);

   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;

   // cs_n chain resets low so a frame already in flight at reset release never
   // looks like a fresh falling edge.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
      .clk(clk), .rst(rst), .d(clkcs), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );

   logic unused_sync;
   assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, sclk_fall};

   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
   logic                   mosi_s, miso_s;

   spi_state_e  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  x_lo_q, x_lo_d, y_lo_q, y_lo_d;
   logic        x_lo_fresh_q, x_lo_fresh_d, y_lo_fresh_q, y_lo_fresh_d;
   logic [15:0] x_data_q, x_data_d, y_data_q, y_data_d;
   logic        x_valid_q, x_valid_d, y_valid_q, y_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        commit;

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign miso_s = miso_sync_q[SYNC_STAGES-1];

   always_comb begin
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], adress};
      miso_sync_d  = {miso_sync_q[SYNC_STAGES-2:0], miso};
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      addr_d       = addr_q;
      x_lo_d       = x_lo_q;
      y_lo_d       = y_lo_q;
      x_lo_fresh_d = x_lo_fresh_q;
      y_lo_fresh_d = y_lo_fresh_q;
      x_data_d     = x_data_q;
      y_data_d     = y_data_q;
      x_valid_d    = 1'b0;
      y_valid_d    = 1'b0;
      frame_err_d  = 1'b0;
      commit       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_CMD;
               cnt_d   = 3'd0;
            end
         end
         ST_CMD, ST_ADDR, ST_DATA: begin
            if (sclk_rise) begin
               shift_d = {shift_q[6:0], (state_q == ST_DATA) ? miso_s : mosi_s};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  case (state_q)
                     ST_CMD:  state_d = (shift_d == READ_CMD) ? ST_ADDR : ST_SKIP;
                     ST_ADDR: begin
                        addr_d  = shift_d;
                        state_d = ST_DATA;
                     end
                     default: begin
                        commit  = 1'b1;
                        state_d = ST_DONE;
                     end
                  endcase
               end
            end
         end
         ST_DONE: state_d = ST_SKIP;
         default: state_d = state_q;
      endcase

      if (cs_rise) begin
         state_d     = ST_IDLE;
         commit      = 1'b0;
         frame_err_d = (state_q == ST_ADDR) || (state_q == ST_DATA);
      end

      // Registering the commit makes the valid pulse and new sample appear
      // together in the DONE cycle.
      if (commit) begin
         if (addr_q == X_LO_ADDR) begin
            x_lo_d       = shift_d;
            x_lo_fresh_d = 1'b1;
         end else if (addr_q == X_HI_ADDR) begin
            if (x_lo_fresh_q) begin
               x_data_d  = {shift_d, x_lo_q};
               x_valid_d = 1'b1;
            end
            x_lo_fresh_d = 1'b0;
         end else if (addr_q == Y_LO_ADDR) begin
            y_lo_d       = shift_d;
            y_lo_fresh_d = 1'b1;
         end else if (addr_q == Y_HI_ADDR) begin
            if (y_lo_fresh_q) begin
               y_data_d  = {shift_d, y_lo_q};
               y_valid_d = 1'b1;
            end
            y_lo_fresh_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_sync_q  <= '0;
         miso_sync_q  <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         shift_q      <= 8'd0;
         addr_q       <= 8'd0;
         x_lo_q       <= 8'd0;
         y_lo_q       <= 8'd0;
         x_lo_fresh_q <= 1'b0;
         y_lo_fresh_q <= 1'b0;
         x_data_q     <= 16'd0;
         y_data_q     <= 16'd0;
         x_valid_q    <= 1'b0;
         y_valid_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         mosi_sync_q  <= mosi_sync_d;
         miso_sync_q  <= miso_sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         addr_q       <= addr_d;
         x_lo_q       <= x_lo_d;
         y_lo_q       <= y_lo_d;
         x_lo_fresh_q <= x_lo_fresh_d;
         y_lo_fresh_q <= y_lo_fresh_d;
         x_data_q     <= x_data_d;
         y_data_q     <= y_data_d;
         x_valid_q    <= x_valid_d;
         y_valid_q    <= y_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign x_data    = x_data_q;
   assign y_data    = y_data_q;
   assign x_valid   = x_valid_q;
   assign y_valid   = y_valid_q;
   assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gravity_sensor_in.sv
// ============================================================================
// tb_gravity_sensor_in : directed frame table plus reset corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gravity_sensor_in;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clkcs = 1'b1;
   logic        sclk = 1'b0;
   logic        adress = 1'b0;
   logic        miso = 1'b0;
   logic [15:0] x_data, y_data;
   logic        x_valid, y_valid, frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int x_cnt = 0;
   int y_cnt = 0;
   int e_cnt = 0;

   always #10 clk = ~clk;

   gravity_sensor_in dut (
      .clk(clk), .rst(rst), .clkcs(clkcs), .sclk(sclk), .adress(adress), .miso(miso),
      .x_data(x_data), .y_data(y_data), .x_valid(x_valid), .y_valid(y_valid),
      .frame_err(frame_err)
   );

   // Counts high cycles, so a stretched pulse shows up as a count above one.
   always @(negedge clk) begin
      if (x_valid)   x_cnt++;
      if (y_valid)   y_cnt++;
      if (frame_err) e_cnt++;
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic [7:0]  data;
      int          nbits;
      int          exp_x;
      int          exp_y;
      int          exp_err;
      logic [15:0] exp_xd;
      logic [15:0] exp_yd;
   } vec_t;

   vec_t vecs[20];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                        input int nbits, input int rst_at);
      logic [23:0] w;
      w = {c, a, d};
      clkcs = 1'b0;
      tick(8);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            tick(3);
            rst = 1'b0;
         end
         if (i < 16) begin
            adress = w[23-i];
            miso   = 1'b0;
         end else if (i < 24) begin
            adress = 1'b0;
            miso   = w[23-i];
         end else begin
            adress = 1'b1;
            miso   = 1'b1;
         end
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
      tick(4);
      clkcs  = 1'b1;
      adress = 1'b0;
      miso   = 1'b0;
      tick(12);
   endtask

   task automatic run_and_check(input string tag, input logic [7:0] c, input logic [7:0] a,
                                input logic [7:0] d, input int nbits, input int rst_at,
                                input int ex, input int ey, input int ee,
                                input logic [15:0] exd, input logic [15:0] eyd);
      int x0, y0, e0;
      x0 = x_cnt;
      y0 = y_cnt;
      e0 = e_cnt;
      frame(c, a, d, nbits, rst_at);
      check({tag, " x_valid pulses"}, x_cnt - x0, ex);
      check({tag, " y_valid pulses"}, y_cnt - y0, ey);
      check({tag, " frame_err pulses"}, e_cnt - e0, ee);
      check({tag, " x_data"}, {16'd0, x_data}, {16'd0, exd});
      check({tag, " y_data"}, {16'd0, y_data}, {16'd0, eyd});
   endtask

   initial begin
      vecs[0]  = '{8'h0B, 8'h0E, 8'h34, 24, 0, 0, 0, 16'h0000, 16'h0000};
      vecs[1]  = '{8'h0B, 8'h0F, 8'h12, 24, 1, 0, 0, 16'h1234, 16'h0000};
      vecs[2]  = '{8'h0B, 8'h10, 8'hCD, 24, 0, 0, 0, 16'h1234, 16'h0000};
      vecs[3]  = '{8'h0B, 8'h11, 8'hAB, 24, 0, 1, 0, 16'h1234, 16'hABCD};
      vecs[4]  = '{8'h0B, 8'h11, 8'hAB, 24, 0, 0, 0, 16'h1234, 16'hABCD};
      vecs[5]  = '{8'h0A, 8'h2D, 8'h02, 24, 0, 0, 0, 16'h1234, 16'hABCD};
      vecs[6]  = '{8'h0B, 8'h0E, 8'h55, 20, 0, 0, 1, 16'h1234, 16'hABCD};
      vecs[7]  = '{8'h0B, 8'h0E, 8'h78, 24, 0, 0, 0, 16'h1234, 16'hABCD};
      vecs[8]  = '{8'h0B, 8'h0F, 8'h9A, 24, 1, 0, 0, 16'h9A78, 16'hABCD};
      vecs[9]  = '{8'h0B, 8'h0F, 8'h11, 24, 0, 0, 0, 16'h9A78, 16'hABCD};
      vecs[10] = '{8'h0C, 8'h0E, 8'h00, 24, 0, 0, 0, 16'h9A78, 16'hABCD};
      vecs[11] = '{8'h0B, 8'h0F, 8'h22, 24, 0, 0, 0, 16'h9A78, 16'hABCD};
      vecs[12] = '{8'h0B, 8'h10, 8'hEF, 28, 0, 0, 0, 16'h9A78, 16'hABCD};
      vecs[13] = '{8'h0B, 8'h11, 8'h01, 24, 0, 1, 0, 16'h9A78, 16'h01EF};
      vecs[14] = '{8'h0B, 8'h0E, 8'h01, 24, 0, 0, 0, 16'h9A78, 16'h01EF};
      vecs[15] = '{8'h0B, 8'h0E, 8'h02, 24, 0, 0, 0, 16'h9A78, 16'h01EF};
      vecs[16] = '{8'h0B, 8'h0F, 8'h80, 24, 1, 0, 0, 16'h8002, 16'h01EF};
      vecs[17] = '{8'h0B, 8'h99, 8'hFF, 24, 0, 0, 0, 16'h8002, 16'h01EF};
      vecs[18] = '{8'h0B, 8'h0F, 8'h01, 16, 0, 0, 1, 16'h8002, 16'h01EF};
      vecs[19] = '{8'h0B, 8'h0E, 8'h00,  4, 0, 0, 0, 16'h8002, 16'h01EF};

      rst = 1'b1;
      tick(3);
      check("reset x_data", {16'd0, x_data}, 32'd0);
      check("reset y_data", {16'd0, y_data}, 32'd0);
      check("reset strobes", {29'd0, x_valid, y_valid, frame_err}, 32'd0);
      check("reset pulse count", x_cnt + y_cnt + e_cnt, 0);
      rst = 1'b0;
      tick(100);
      check("idle pulse count", x_cnt + y_cnt + e_cnt, 0);
      check("idle x_data", {16'd0, x_data}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         run_and_check($sformatf("v%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].data,
                       vecs[i].nbits, -1, vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_err,
                       vecs[i].exp_xd, vecs[i].exp_yd);
      end

      // Reset partway through an X_HI frame: registers clear, the tail is ignored.
      run_and_check("rst_lo", 8'h0B, 8'h0E, 8'h11, 24, -1, 0, 0, 0, 16'h8002, 16'h01EF);
      run_and_check("rst_mid", 8'h0B, 8'h0F, 8'h22, 24, 12, 0, 0, 0, 16'h0000, 16'h0000);
      run_and_check("rst_after_lo", 8'h0B, 8'h0E, 8'h44, 24, -1, 0, 0, 0, 16'h0000, 16'h0000);
      run_and_check("rst_after_hi", 8'h0B, 8'h0F, 8'h33, 24, -1, 1, 0, 0, 16'h3344, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
